switch_sequencer: RTL and testbench
===================================

// Module: switch_sequencer
// PURPOSE
//  Scheduler for the photonic switch bank. Steps round-robin through up to NCH
//  enabled switch channels and drives one-hot switch selects, break-before-make.
//  For each channel: settle time, then a req/ack handshake to the receiver/ADC
//  capture path, then a dwell time. All timing uses a programmable prescaler tick.
//  Sits between the host configuration registers and the switch drivers/receivers.
// PARAMETERS
//  NCH      4  number of switch channels (2..16); IDX_W = $clog2(NCH) (localparam)
//  PRESC_W  8  width of prescale value
//  TIME_W   8  width of settle/dwell counts (in ticks)
// PORTS
//  clk         in   1        system clock
//  reset       in   1        asynchronous, active-low reset
//  start       in   1        begin a sequence (sampled only in IDLE)
//  stop        in   1        synchronous abort, highest priority
//  continuous  in   1        1: wrap to lowest enabled channel forever
//  prescale    in   PRESC_W  tick period = prescale+1 clk cycles
//  settle      in   TIME_W   ticks between switch-on and sample request
//  dwell       in   TIME_W   ticks held after sample ack
//  chan_mask   in   NCH      channel enable mask, bit i = channel i
//  sample_ack  in   1        receiver accepted sample request
//  sw_sel      out  NCH      one-hot switch drive, 0 = all off
//  chan_idx    out  IDX_W    index of the current/last channel
//  sample_req  out  1        sample request, held until acked
//  busy        out  1        high in every state except IDLE
//  done        out  1        one-cycle pulse at normal sequence completion
// BEHAVIOUR
//  - Reset: state IDLE; sw_sel=0, chan_idx=0, sample_req=0, busy=0, done=0,
//    prescaler=0, tick counter=0. All outputs are registered.
//  - FSM states: IDLE, SELECT, SETTLE, SAMPLE, DWELL.
//  - IDLE: on start=1 && stop=0, latch prescale/settle/dwell/chan_mask/continuous.
//    Start from pointer 0 -> SELECT. If the latched mask is 0: done=1 for one
//    cycle, remain IDLE, busy stays 0. A start while busy is ignored.
//  - SELECT (exactly 1 cycle): sw_sel=0. Pick the lowest enabled index >= pointer.
//    Load chan_idx, go to SETTLE. sw_sel = onehot(chan_idx) from SETTLE entry.
//  - Tick: prescaler counts 0..prescale and ticks on the cycle where it equals
//    prescale, then wraps. It clears on every entry to SETTLE or DWELL.
//  - SETTLE/DWELL last exactly N*(prescale+1) cycles (N = settle or dwell).
//    N=0 means the state lasts 1 cycle.
//  - SAMPLE: sample_req=1 from entry. On a clk edge with sample_ack=1: req=0 on
//    the next cycle -> DWELL. No timeout. sample_ack outside SAMPLE is ignored.
//  - DWELL exit: if an enabled channel > chan_idx exists, pointer=chan_idx+1,
//    -> SELECT. Else if continuous, pointer=0, -> SELECT.
//    Else -> IDLE with sw_sel=0, busy=0, done=1 for one cycle.
//  - Break-before-make: consecutive channels, including a wrap to the same
//    single channel, always have >=1 cycle of sw_sel=0. sw_sel never multi-hot.
//  - stop=1 in any non-IDLE state: next cycle IDLE, sw_sel=0, sample_req=0,
//    busy=0, no done pulse. chan_idx keeps its value.
//  - stop and start both high in IDLE: no sequence starts.
//  - Config inputs changed mid-sequence have no effect until the next start.
//  - Async reset mid-sequence: outputs go to reset values immediately.
// TESTING
//  1 NCH=4, prescale=1, settle=2, dwell=3, mask=0101, ack tied 1, single run ->
//    SELECT; sw_sel=0001 for 11 cycles (4 settle + 1 req + 6 dwell);
//    1 cycle 0000; sw_sel=0100 for 11 cycles; then done pulse, busy=0.
//  2 mask=0000, start -> done pulse next cycle, busy never rises, sw_sel=0.
//  3 ack delayed 5 cycles -> sample_req high exactly 5 cycles, sw_sel held.
//    DWELL starts the cycle after ack.
//  4 continuous=1, mask=1000 -> 3,3,3... with one 0000 gap between visits.
//    No done pulse; stop during DWELL -> next cycle sw_sel=0, busy=0, done=0.
//  5 settle=0, dwell=0, prescale=0 -> SETTLE and DWELL each last 1 cycle.
//    Per-channel period = 4 cycles with ack tied 1.
//  6 reset low mid-SAMPLE -> sw_sel, sample_req, busy drop without a clock edge.
//    A restart after release behaves as in scenario 1.

Source files
------------

// File: rtl/switch_sequencer_if.sv
// Switch-bank side of the sequencer: one-hot switch drive, channel index,
// and the sample request/acknowledge handshake with the receiver/ADC path.
interface switch_sequencer_if #(
    parameter int NCH = 4
);
    localparam int IDX_W = $clog2(NCH);

    logic [NCH-1:0]   sw_sel;
    logic [IDX_W-1:0] chan_idx;
    logic             sample_req;
    logic             sample_ack;

    modport master (
        output sw_sel,
        output chan_idx,
        output sample_req,
        input  sample_ack
    );

    modport slave (
        input  sw_sel,
        input  chan_idx,
        input  sample_req,
        output sample_ack
    );
endinterface

// File: rtl/switch_sequencer.sv
// Round-robin scheduler for the photonic switch bank. Each enabled channel is
// switched on, allowed to settle, sampled through a req/ack handshake, then
// held for a dwell time. A blank SELECT cycle between channels guarantees
// break-before-make. All outputs are registered from the next-state decode.
module switch_sequencer #(
    parameter int NCH     = 4,
    parameter int PRESC_W = 8,
    parameter int TIME_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [TIME_W-1:0]  settle,
    input  logic [TIME_W-1:0]  dwell,
    input  logic [NCH-1:0]     chan_mask,
    switch_sequencer_if.master bus,
    output logic               busy,
    output logic               done
);
    localparam int IDX_W = $clog2(NCH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DWELL  = 3'd4
    } state_t;

    state_t state, next_state;

    // Configuration captured at start; mid-sequence input changes are ignored.
    logic [PRESC_W-1:0] presc_l;
    logic [TIME_W-1:0]  settle_l;
    logic [TIME_W-1:0]  dwell_l;
    logic [NCH-1:0]     mask_l;
    logic               cont_l;

    logic [PRESC_W-1:0] presc_cnt;
    logic [TIME_W-1:0]  tick_cnt;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [NCH-1:0]     sw_sel_q, sw_sel_d;
    logic [IDX_W-1:0]   chan_idx_q, chan_idx_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               launch;
    logic               tick;
    logic               settle_end;
    logic               dwell_end;
    logic [IDX_W-1:0]   pick;
    logic               higher;

    assign launch     = start && !stop;
    assign tick       = (presc_cnt == presc_l);
    assign settle_end = (settle_l == '0) || (tick && (tick_cnt == settle_l - TIME_W'(1)));
    assign dwell_end  = (dwell_l == '0) || (tick && (tick_cnt == dwell_l - TIME_W'(1)));

    // Channel search: lowest enabled index at or above the pointer, and
    // whether any enabled channel lies above the current one.
    always_comb begin
        pick   = '0;
        higher = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_l[i] && (IDX_W'(i) >= ptr_q)) pick = IDX_W'(i);
            if (mask_l[i] && (IDX_W'(i) > chan_idx_q)) higher = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode; stop overrides every non-idle transition.
    always_comb begin
        next_state = state;
        ptr_d      = ptr_q;
        case (state)
            IDLE: begin
                if (launch && (chan_mask != '0)) begin
                    next_state = SELECT;
                    ptr_d      = '0;
                end
            end
            SELECT: next_state = SETTLE;
            SETTLE: if (settle_end) next_state = SAMPLE;
            SAMPLE: if (bus.sample_ack) next_state = DWELL;
            DWELL: begin
                if (dwell_end) begin
                    if (higher) begin
                        next_state = SELECT;
                        ptr_d      = chan_idx_q + IDX_W'(1);
                    end else if (cont_l) begin
                        next_state = SELECT;
                        ptr_d      = '0;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if ((state != IDLE) && stop) next_state = IDLE;
    end

    // Output decode from the upcoming state so registered outputs align with it.
    always_comb begin
        chan_idx_d = chan_idx_q;
        sw_sel_d   = '0;
        req_d      = 1'b0;
        busy_d     = (next_state != IDLE);
        done_d     = 1'b0;
        if ((state == SELECT) && !stop) chan_idx_d = pick;
        if ((next_state == SETTLE) || (next_state == SAMPLE) || (next_state == DWELL))
            sw_sel_d = NCH'(1) << chan_idx_d;
        if (next_state == SAMPLE) req_d = 1'b1;
        if ((state == IDLE) && launch && (chan_mask == '0)) done_d = 1'b1;
        if ((state == DWELL) && dwell_end && !higher && !cont_l && !stop) done_d = 1'b1;
    end

    // Output, pointer and timing-counter registers; counters restart on each state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_sel_q   <= '0;
            chan_idx_q <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ptr_q      <= '0;
            presc_cnt  <= '0;
            tick_cnt   <= '0;
        end else begin
            sw_sel_q   <= sw_sel_d;
            chan_idx_q <= chan_idx_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ptr_q      <= ptr_d;
            if (state != next_state) begin
                presc_cnt <= '0;
                tick_cnt  <= '0;
            end else if ((state == SETTLE) || (state == DWELL)) begin
                if (tick) begin
                    presc_cnt <= '0;
                    tick_cnt  <= tick_cnt + TIME_W'(1);
                end else begin
                    presc_cnt <= presc_cnt + PRESC_W'(1);
                end
            end
        end
    end

    // Configuration latch, loaded only when a sequence is launched from idle.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && launch) begin
            presc_l  <= prescale;
            settle_l <= settle;
            dwell_l  <= dwell;
            mask_l   <= chan_mask;
            cont_l   <= continuous;
        end
    end

    assign bus.sw_sel     = sw_sel_q;
    assign bus.chan_idx   = chan_idx_q;
    assign bus.sample_req = req_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_switch_sequencer.sv
// Directed bench for switch_sequencer: inputs change and outputs are sampled
// on the falling clock edge; expected traces are written out by hand.
module tb_switch_sequencer;
    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       continuous;
    logic [7:0] prescale;
    logic [7:0] settle;
    logic [7:0] dwell;
    logic [3:0] chan_mask;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    switch_sequencer_if #(.NCH(4)) bus ();

    switch_sequencer #(.NCH(4), .PRESC_W(8), .TIME_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .prescale   (prescale),
        .settle     (settle),
        .dwell      (dwell),
        .chan_mask  (chan_mask),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        prescale = 8'd0; settle = 8'd0; dwell = 8'd0; chan_mask = 4'b0000;
        bus.sample_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.sw_sel !== 4'b0000) begin errors++; $display("FAIL reset sw_sel got %b exp 0000", bus.sw_sel); end
        checks++; if (bus.chan_idx !== 2'd0) begin errors++; $display("FAIL reset chan_idx got %0d exp 0", bus.chan_idx); end
        checks++; if ({bus.sample_req, busy, done} !== 3'b000) begin errors++; $display("FAIL reset req/busy/done got %b exp 000", {bus.sample_req, busy, done}); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({bus.sw_sel, busy, done} !== 6'b0) begin errors++; $display("FAIL idle_after_reset got %b exp 000000", {bus.sw_sel, busy, done}); end
    endtask

    // mask 0101, prescale 1, settle 2, dwell 3, ack tied high.
    task automatic test_single_run(input string tag);
        logic [3:0] exp_sw;
        logic       exp_req, exp_busy, exp_done;
        prescale = 8'd1; settle = 8'd2; dwell = 8'd3; chan_mask = 4'b0101;
        continuous = 1'b0; bus.sample_ack = 1'b1;
        start = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp_sw   = (k >= 1 && k <= 11) ? 4'b0001 : (k >= 13 && k <= 23) ? 4'b0100 : 4'b0000;
            exp_req  = (k == 5) || (k == 17);
            exp_busy = (k <= 23);
            exp_done = (k == 24);
            checks++; if (bus.sw_sel !== exp_sw) begin errors++; $display("FAIL %s sw_sel k=%0d got %b exp %b", tag, k, bus.sw_sel, exp_sw); end
            checks++; if ({bus.sample_req, busy, done} !== {exp_req, exp_busy, exp_done}) begin errors++; $display("FAIL %s req/busy/done k=%0d got %b exp %b", tag, k, {bus.sample_req, busy, done}, {exp_req, exp_busy, exp_done}); end
            if (k == 1 || k == 13) begin
                checks++; if (bus.chan_idx !== ((k == 1) ? 2'd0 : 2'd2)) begin errors++; $display("FAIL %s chan_idx k=%0d got %0d exp %0d", tag, k, bus.chan_idx, (k == 1) ? 0 : 2); end
            end
        end
    endtask

    task automatic test_empty_mask();
        chan_mask = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({bus.sw_sel, busy, done} !== 6'b000001) begin errors++; $display("FAIL empty_mask pulse got %b exp 000001", {bus.sw_sel, busy, done}); end
        @(negedge clk);
        checks++; if ({bus.sw_sel, busy, done} !== 6'b000000) begin errors++; $display("FAIL empty_mask after got %b exp 000000", {bus.sw_sel, busy, done}); end
    endtask

    task automatic test_start_stop();
        chan_mask = 4'b0001; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL start_stop busy/done got %b exp 00", {busy, done}); end
        @(negedge clk);
        checks++; if ({bus.sw_sel, busy} !== 5'b00000) begin errors++; $display("FAIL start_stop later got %b exp 00000", {bus.sw_sel, busy}); end
    endtask

    // Ack pulsed while in SELECT (ignored), then asserted on the fifth SAMPLE cycle.
    task automatic test_delayed_ack();
        int req_cycles = 0;
        logic [3:0] exp_sw;
        prescale = 8'd0; settle = 8'd1; dwell = 8'd0; chan_mask = 4'b0010;
        continuous = 1'b0; bus.sample_ack = 1'b0;
        start = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.sample_req) req_cycles++;
            exp_sw = (k >= 1 && k <= 7) ? 4'b0010 : 4'b0000;
            checks++; if (bus.sw_sel !== exp_sw) begin errors++; $display("FAIL delayed_ack sw_sel k=%0d got %b exp %b", k, bus.sw_sel, exp_sw); end
            checks++; if (bus.sample_req !== (k >= 2 && k <= 6)) begin errors++; $display("FAIL delayed_ack req k=%0d got %b exp %b", k, bus.sample_req, (k >= 2 && k <= 6)); end
            checks++; if (done !== (k == 8)) begin errors++; $display("FAIL delayed_ack done k=%0d got %b exp %b", k, done, (k == 8)); end
            bus.sample_ack = (k == 0) || (k == 6);
        end
        checks++; if (req_cycles != 5) begin errors++; $display("FAIL delayed_ack req_len got %0d exp 5", req_cycles); end
    endtask

    // Single channel 3 forever; config inputs disturbed mid-run; stop in DWELL.
    task automatic test_continuous_stop();
        logic [3:0] exp_sw;
        prescale = 8'd0; settle = 8'd0; dwell = 8'd0; chan_mask = 4'b1000;
        continuous = 1'b1; bus.sample_ack = 1'b1;
        start = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 2) begin chan_mask = 4'b0001; continuous = 1'b0; start = 1'b1; end
            else start = 1'b0;
            exp_sw = ((k % 4) == 0) ? 4'b0000 : 4'b1000;
            checks++; if (bus.sw_sel !== exp_sw) begin errors++; $display("FAIL continuous sw_sel k=%0d got %b exp %b", k, bus.sw_sel, exp_sw); end
            checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL continuous busy/done k=%0d got %b exp 10", k, {busy, done}); end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++; if ({bus.sw_sel, bus.sample_req, busy, done} !== 7'b0) begin errors++; $display("FAIL stop outputs got %b exp 0000000", {bus.sw_sel, bus.sample_req, busy, done}); end
        checks++; if (bus.chan_idx !== 2'd3) begin errors++; $display("FAIL stop chan_idx got %0d exp 3", bus.chan_idx); end
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL stop later got %b exp 00", {busy, done}); end
    endtask

    // Zero settle/dwell/prescale: 4-cycle channel period, mask 0011.
    task automatic test_min_timing();
        logic [3:0] exp_sw;
        prescale = 8'd0; settle = 8'd0; dwell = 8'd0; chan_mask = 4'b0011;
        continuous = 1'b0; bus.sample_ack = 1'b1;
        start = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp_sw = (k >= 1 && k <= 3) ? 4'b0001 : (k >= 5 && k <= 7) ? 4'b0010 : 4'b0000;
            checks++; if (bus.sw_sel !== exp_sw) begin errors++; $display("FAIL min_timing sw_sel k=%0d got %b exp %b", k, bus.sw_sel, exp_sw); end
            checks++; if ({bus.sample_req, done} !== {(k == 2 || k == 6), (k == 8)}) begin errors++; $display("FAIL min_timing req/done k=%0d got %b exp %b", k, {bus.sample_req, done}, {(k == 2 || k == 6), (k == 8)}); end
        end
    endtask

    // Async reset while waiting for ack on channel 2, then a fresh run.
    task automatic test_reset_mid_sample();
        prescale = 8'd1; settle = 8'd2; dwell = 8'd3; chan_mask = 4'b0100;
        continuous = 1'b0; bus.sample_ack = 1'b0;
        start = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if ({bus.sw_sel, bus.sample_req, busy} !== 6'b010011) begin errors++; $display("FAIL pre_reset got %b exp 010011", {bus.sw_sel, bus.sample_req, busy}); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({bus.sw_sel, bus.sample_req, busy} !== 6'b000000) begin errors++; $display("FAIL async_reset got %b exp 000000", {bus.sw_sel, bus.sample_req, busy}); end
        checks++; if (bus.chan_idx !== 2'd0) begin errors++; $display("FAIL async_reset chan_idx got %0d exp 0", bus.chan_idx); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_single_run("restart");
    endtask

    initial begin
        test_reset();
        test_single_run("single_run");
        test_empty_mask();
        test_start_stop();
        test_delayed_ack();
        test_continuous_stop();
        test_min_timing();
        test_reset_mid_sample();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
